modadd_stream: RTL

//  Streaming modular adder: C = (A + B) mod q, the additive counterpart of the modsub datapath.

---
 rtl/modop_pkg.sv | 14 +
 rtl/modop_pipe_reg.sv | 43 ++++
 rtl/modadd_stream.sv | 110 +++++++++++
 3 files changed

// File: rtl/modop_pkg.sv
// Shared definitions for the streaming modular-arithmetic blocks (modadd/modsub/modmul).
package modop_pkg;

  typedef struct packed {
    logic ff_in;
    logic ff_add;
    logic ff_out;
  } modadd_params_t;

  function automatic int unsigned modadd_lat(input modadd_params_t p);
    return 32'(p.ff_in) + 32'(p.ff_add) + 32'(p.ff_out);
  endfunction

endpackage

// File: rtl/modop_pipe_reg.sv
// One elastic valid/ready register slice; EN=0 turns it into plain wires.
module modop_pipe_reg #(
  parameter int unsigned W  = 8,
  parameter bit          EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  if (EN) begin : g_reg
    logic         valid;
    logic [W-1:0] data;
    logic         adv;

    // Slice moves when empty or when downstream takes its content.
    assign adv = !valid || dn_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid <= 1'b0;
        data  <= '0;
      end else if (adv) begin
        valid <= up_valid;
        if (up_valid) data <= up_data;
      end
    end

    assign up_ready = adv;
    assign dn_valid = valid;
    assign dn_data  = data;
  end else begin : g_wire
    assign up_ready = dn_ready;
    assign dn_valid = up_valid;
    assign dn_data  = up_data;
  end

endmodule

// File: rtl/modadd_stream.sv
// Streaming modular adder C = (A + B) mod q with elastic stage registers.
// Optional range check on the operands: define MODADD_RANGE_CHK_EN to add out_err.
module modadd_stream
  import modop_pkg::*;
#(
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 47,
  parameter int unsigned FF_IN  = 1,
  parameter int unsigned FF_ADD = 1,
  parameter int unsigned FF_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] A,
  input  logic [LOGQ-1:0] B,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] C
`ifdef MODADD_RANGE_CHK_EN
  ,
  output logic            out_err
`endif
);

  localparam int unsigned W = LOGQ - LOGQH;
`ifdef MODADD_RANGE_CHK_EN
  localparam int unsigned XW = 1;
`else
  localparam int unsigned XW = 0;
`endif
  localparam modadd_params_t P = '{ff_in:  (FF_IN  != 0),
                                   ff_add: (FF_ADD != 0),
                                   ff_out: (FF_OUT != 0)};
  localparam int unsigned D0W = 3 * LOGQ + XW;
  localparam int unsigned D1W = 2 * LOGQ + 3 + XW;
  localparam int unsigned D2W = LOGQ + XW;
  // Only q_hi and q[0] take part in the subtraction; the middle bits are zero by construction.
  localparam logic [LOGQ-1:0] QMASK = {{LOGQH{1'b1}}, {(W - 1){1'b0}}, 1'b1};

  logic [D0W-1:0]  in_data, s1_data;
  logic [D1W-1:0]  add_data, s2_data;
  logic [D2W-1:0]  sel_data, s3_data;
  logic            s1_valid, s2_valid;
  logic            ready_add, ready_out;

  logic [LOGQ-1:0] a1, b1, q1;
  logic [LOGQ:0]   sum, sum2;
  logic [LOGQ+1:0] diff, diff2;
  logic [LOGQ-1:0] c_sel;
  logic            unused_carry;

  modop_pipe_reg #(.W(D0W), .EN(P.ff_in)) u_ff_in (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .up_data  (in_data),
    .dn_valid (s1_valid),
    .dn_ready (ready_add),
    .dn_data  (s1_data)
  );

  assign {a1, b1, q1} = s1_data[3*LOGQ-1:0];
  assign sum  = {1'b0, a1} + {1'b0, b1};
  assign diff = {1'b0, sum} - {2'b00, q1 & QMASK};

  modop_pipe_reg #(.W(D1W), .EN(P.ff_add)) u_ff_add (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s1_valid),
    .up_ready (ready_add),
    .up_data  (add_data),
    .dn_valid (s2_valid),
    .dn_ready (ready_out),
    .dn_data  (s2_data)
  );

  // A negative difference means the sum was already below q.
  assign {sum2, diff2} = s2_data[2*LOGQ+2:0];
  assign c_sel         = diff2[LOGQ+1] ? sum2[LOGQ-1:0] : diff2[LOGQ-1:0];
  assign unused_carry  = ^{sum2[LOGQ], diff2[LOGQ]};

  modop_pipe_reg #(.W(D2W), .EN(P.ff_out)) u_ff_out (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s2_valid),
    .up_ready (ready_out),
    .up_data  (sel_data),
    .dn_valid (out_valid),
    .dn_ready (out_ready),
    .dn_data  (s3_data)
  );

  assign C = s3_data[LOGQ-1:0];

`ifdef MODADD_RANGE_CHK_EN
  assign in_data  = {(A >= q) || (B >= q), A, B, q};
  assign add_data = {s1_data[3*LOGQ], sum, diff};
  assign sel_data = {s2_data[2*LOGQ+3], c_sel};
  assign out_err  = s3_data[LOGQ];
`else
  assign in_data  = {A, B, q};
  assign add_data = {sum, diff};
  assign sel_data = c_sel;
`endif

endmodule
